// File: rtl/prim_reqack_arb_pkg.sv
// Shared types and constants for the round-robin REQ/ACK channel arbiter.
package prim_reqack_arb_pkg;

  // Arbiter FSM: IDLE waits for a requester, BUSY holds the channel REQ until ACK.
  typedef enum logic {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } reqack_arb_state_e;

  // Internal width of the saturating watchdog counter.
  localparam int unsigned WdogW = 16;

endpackage

// File: rtl/prim_rr_pick.sv
// Combinational round-robin picker: first set request bit after 'last', with wrap.
module prim_rr_pick #(
  parameter int NumReq = 4,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic              valid,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW-1:0] cand;

  // Walk offsets from the farthest to the nearest so the nearest set bit after last wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    for (int off = NumReq; off >= 1; off--) begin
      cand = IdxW'((int'(last) + off) % NumReq);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/prim_reqack_arb.sv
// Round-robin arbiter sharing one SRC-side REQ/ACK CDC channel among NumReq requesters.
//
// Handshake: requester i raises req_i[i] and holds it until ack_o[i] pulses for one
// cycle. The channel side mirrors this: chan_req_o is raised on grant and held until
// chan_ack_i pulses; that pulse is routed combinationally to the granted requester.
module prim_reqack_arb
  import prim_reqack_arb_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 255,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] ack_o,
  output logic              chan_req_o,
  input  logic              chan_ack_i,
  output logic [IdxW-1:0]   chan_id_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              spurious_ack_o,
  input  logic              clr_err_i,
  output reqack_arb_state_e state_o
);

  localparam logic [WdogW-1:0] TimeoutLim = WdogW'(TimeoutCycles);
  localparam logic [IdxW-1:0]  LastInit   = IdxW'(NumReq - 1);

  reqack_arb_state_e state_q;
  logic [IdxW-1:0]   last_q;
  logic [WdogW-1:0]  wdog_q;
  logic [WdogW-1:0]  wdog_inc;
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              timeout_set;
  logic              spurious_set;

  prim_rr_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .req   (req_i),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign state_o = state_q;

  // Watchdog increment saturates; the flag sets on the edge where the count reaches the limit.
  always_comb begin
    wdog_inc     = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
    timeout_set  = (state_q == ArbBusy) && (TimeoutCycles != 0) && (wdog_inc == TimeoutLim);
    spurious_set = (state_q == ArbIdle) && chan_ack_i;
  end

  // Return the channel ACK to the granted requester only while a transaction is open.
  always_comb begin
    ack_o = '0;
    if (state_q == ArbBusy && chan_ack_i) begin
      ack_o[chan_id_o] = 1'b1;
    end
  end

  // Main FSM with registered channel outputs, watchdog and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ArbIdle;
      chan_req_o     <= 1'b0;
      chan_id_o      <= '0;
      busy_o         <= 1'b0;
      last_q         <= LastInit;
      wdog_q         <= '0;
      timeout_o      <= 1'b0;
      spurious_ack_o <= 1'b0;
    end else begin
      case (state_q)
        ArbIdle: begin
          if (pick_valid) begin
            state_q    <= ArbBusy;
            chan_req_o <= 1'b1;
            busy_o     <= 1'b1;
            chan_id_o  <= pick_idx;
            last_q     <= pick_idx;
            wdog_q     <= '0;
          end
        end
        ArbBusy: begin
          wdog_q <= wdog_inc;
          if (chan_ack_i) begin
            state_q    <= ArbIdle;
            chan_req_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ArbIdle;
          chan_req_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase

      if (timeout_set) begin
        timeout_o <= 1'b1;
      end else if (clr_err_i) begin
        timeout_o <= 1'b0;
      end

      if (spurious_set) begin
        spurious_ack_o <= 1'b1;
      end else if (clr_err_i) begin
        spurious_ack_o <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  logic chk_armed;
  logic chk_hold_req;
  logic chk_chan_req;
  logic chk_chan_ack;

  // Protocol checks, evaluated on each clock edge against the previous edge's samples.
  always @(posedge clk_i) begin
    chk_armed    <= !rst_i;
    chk_hold_req <= !rst_i && (state_q == ArbBusy) && !chan_ack_i && req_i[chan_id_o];
    chk_chan_req <= chan_req_o;
    chk_chan_ack <= chan_ack_i;
    if (!rst_i) begin
      a_ack_onehot0: assert ($onehot0(ack_o))
        else $error("ack_o not onehot0: %b", ack_o);
      a_ack_in_busy: assert ((ack_o == '0) || (chan_ack_i && state_q == ArbBusy))
        else $error("ack_o raised outside a BUSY ACK cycle");
      if (chk_armed && chk_hold_req) begin
        a_req_held: assert (req_i[chan_id_o])
          else $error("granted req_i[%0d] fell before its ack", chan_id_o);
      end
      if (chk_armed && chk_chan_req && !chan_req_o) begin
        a_chan_req_held: assert (chk_chan_ack)
          else $error("chan_req_o fell without chan_ack_i");
      end
    end
  end
`endif

endmodule

// File: tb/tb_prim_reqack_arb.sv
// Directed bench for prim_reqack_arb (NumReq=4, TimeoutCycles=10).
module tb_prim_reqack_arb;
  import prim_reqack_arb_pkg::*;

  localparam int NumReq = 4;
  localparam int IdxW   = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NumReq-1:0] req_i;
  logic [NumReq-1:0] ack_o;
  logic              chan_req_o;
  logic              chan_ack_i;
  logic [IdxW-1:0]   chan_id_o;
  logic              busy_o;
  logic              timeout_o;
  logic              spurious_ack_o;
  logic              clr_err_i;
  reqack_arb_state_e state_o;

  int n_vec = 0;
  int n_mis = 0;

  prim_reqack_arb #(
    .NumReq        (NumReq),
    .TimeoutCycles (10)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .ack_o          (ack_o),
    .chan_req_o     (chan_req_o),
    .chan_ack_i     (chan_ack_i),
    .chan_id_o      (chan_id_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o),
    .spurious_ack_o (spurious_ack_o),
    .clr_err_i      (clr_err_i),
    .state_o        (state_o)
  );

  // Clock: rising edges at 5, 15, 25, ...; inputs change and outputs are sampled near falling edges.
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".chan_req"}, 32'(chan_req_o), 32'd0);
    chk({tag, ".busy"},     32'(busy_o),     32'd0);
    chk({tag, ".state"},    32'(state_o),    32'(ArbIdle));
  endtask

  task automatic chk_grant(input string tag, input int id);
    chk({tag, ".chan_req"}, 32'(chan_req_o), 32'd1);
    chk({tag, ".busy"},     32'(busy_o),     32'd1);
    chk({tag, ".id"},       32'(chan_id_o),  32'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL bench_timeout: observed run still active expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst_i      = 1'b1;
    req_i      = '0;
    chan_ack_i = 1'b0;
    clr_err_i  = 1'b0;
    tick();
    tick();
    #1;
    // Reset state
    chk_idle("rst");
    chk("rst.id",       32'(chan_id_o),      32'd0);
    chk("rst.ack",      32'(ack_o),          32'd0);
    chk("rst.timeout",  32'(timeout_o),      32'd0);
    chk("rst.spurious", 32'(spurious_ack_o), 32'd0);
    rst_i = 1'b0;

    // 1: single requester 2, ACK five cycles after the grant
    tick();
    req_i = 4'b0100;
    tick(); #1;
    chk_grant("t1.grant", 2);
    repeat (4) tick();
    chan_ack_i = 1'b1; #1;
    chk("t1.ack", 32'(ack_o), 32'b0100);
    chk("t1.busy_at_ack", 32'(busy_o), 32'd1);
    tick();
    chan_ack_i = 1'b0;
    req_i      = 4'b0000; #1;
    chk_idle("t1.after");
    chk("t1.ack_gone", 32'(ack_o), 32'd0);

    // 2: all requesters active after a fresh reset, grants rotate 0,1,2,3,0
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_i = 4'b1111;
    tick(); #1;
    for (int g = 0; g < 5; g++) begin
      chk_grant($sformatf("t2.g%0d", g), g % 4);
      tick(); tick(); tick();
      chan_ack_i = 1'b1; #1;
      chk($sformatf("t2.ack%0d", g), 32'(ack_o), 32'(1 << (g % 4)));
      tick();
      chan_ack_i = 1'b0;
      if (g == 4) req_i = 4'b0000;
      #1;
      chk_idle($sformatf("t2.gap%0d", g));
      chk($sformatf("t2.noack%0d", g), 32'(ack_o), 32'd0);
      tick(); #1;
    end
    chk_idle("t2.end");

    // 3: grant to 1, requester 0 arrives mid-transaction
    req_i = 4'b0010;
    tick(); #1;
    chk_grant("t3.grant1", 1);
    req_i = 4'b0011;
    tick(); #1;
    chk_grant("t3.frozen", 1);
    tick();
    chan_ack_i = 1'b1; #1;
    chk("t3.ack1", 32'(ack_o), 32'b0010);
    tick();
    chan_ack_i = 1'b0;
    req_i      = 4'b0001; #1;
    chk_idle("t3.gap");
    tick(); #1;
    chk_grant("t3.grant0", 0);
    chan_ack_i = 1'b1; #1;
    chk("t3.ack0", 32'(ack_o), 32'b0001);
    tick();
    chan_ack_i = 1'b0;
    req_i      = 4'b0000; #1;
    chk_idle("t3.end");

    // 4: watchdog after 10 BUSY cycles, late ACK, then clear
    req_i = 4'b0100;
    tick(); #1;
    chk_grant("t4.grant", 2);
    repeat (9) tick();
    #1;
    chk("t4.timeout_b10", 32'(timeout_o), 32'd0);
    tick(); #1;
    chk("t4.timeout_b11", 32'(timeout_o), 32'd1);
    chk("t4.req_held",    32'(chan_req_o), 32'd1);
    chan_ack_i = 1'b1; #1;
    chk("t4.late_ack", 32'(ack_o), 32'b0100);
    tick();
    chan_ack_i = 1'b0;
    req_i      = 4'b0000; #1;
    chk_idle("t4.done");
    chk("t4.sticky", 32'(timeout_o), 32'd1);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0; #1;
    chk("t4.cleared", 32'(timeout_o), 32'd0);

    // 5: spurious ACK while IDLE; set wins over a simultaneous clear
    chan_ack_i = 1'b1; #1;
    chk("t5.no_ack", 32'(ack_o), 32'd0);
    tick();
    chan_ack_i = 1'b0; #1;
    chk("t5.spur_set", 32'(spurious_ack_o), 32'd1);
    chk_idle("t5.idle");
    chan_ack_i = 1'b1;
    clr_err_i  = 1'b1;
    tick();
    chan_ack_i = 1'b0;
    clr_err_i  = 1'b0; #1;
    chk("t5.set_wins", 32'(spurious_ack_o), 32'd1);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0; #1;
    chk("t5.cleared", 32'(spurious_ack_o), 32'd0);

    // 6: reset while BUSY clears everything and restarts the search at index 0
    chan_ack_i = 1'b1;
    tick();
    chan_ack_i = 1'b0;
    req_i      = 4'b0010;
    tick(); #1;
    chk_grant("t6.grant1", 1);
    chk("t6.spur_pre", 32'(spurious_ack_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_i = 4'b0110; #1;
    chk_idle("t6.rst");
    chk("t6.id",       32'(chan_id_o),      32'd0);
    chk("t6.spurious", 32'(spurious_ack_o), 32'd0);
    chk("t6.timeout",  32'(timeout_o),      32'd0);
    tick(); #1;
    chk_grant("t6.regrant", 1);
    chan_ack_i = 1'b1; #1;
    chk("t6.ack", 32'(ack_o), 32'b0010);
    tick();
    chan_ack_i = 1'b0;
    req_i      = 4'b0000; #1;
    chk_idle("t6.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
